// File: rtl/apb_arbiter_master.sv
// Two-requester APB master: round-robin arbitration into a single APB
// SETUP/ACCESS sequence with a bounded wait-state timeout.
module apb_arbiter_master #(
  parameter int ADDRESSWIDTH = 4,
  parameter int DATAWIDTH    = 32,
  parameter int TIMEOUT      = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [1:0]              req_valid,
  input  logic [ADDRESSWIDTH-1:0] req0_addr,
  input  logic [ADDRESSWIDTH-1:0] req1_addr,
  input  logic [DATAWIDTH-1:0]    req0_wdata,
  input  logic [DATAWIDTH-1:0]    req1_wdata,
  input  logic                    req0_write,
  input  logic                    req1_write,
  output logic [1:0]              req_done,
  output logic                    req_err,
  output logic [DATAWIDTH-1:0]    req_rdata,
  output logic                    PSELx,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDRESSWIDTH-1:0] PADDR,
  output logic [DATAWIDTH-1:0]    PWDATA,
  input  logic [DATAWIDTH-1:0]    PRDATA,
  input  logic                    PREADY
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                  r_state, w_state_next;
  logic                    r_psel, w_psel_next;
  logic                    r_penable, w_penable_next;
  logic                    r_pwrite, w_pwrite_next;
  logic [ADDRESSWIDTH-1:0] r_paddr, w_paddr_next;
  logic [DATAWIDTH-1:0]    r_pwdata, w_pwdata_next;
  logic [1:0]              r_done, w_done_next;
  logic                    r_err, w_err_next;
  logic [DATAWIDTH-1:0]    r_rdata, w_rdata_next;
  logic [CW-1:0]           r_cnt, w_cnt_next;
  logic                    r_last_grant, w_last_grant_next;
  logic                    r_grant, w_grant_next;

  logic [1:0]              w_eligible;
  logic                    w_winner;

  // A requester whose done pulse is showing this cycle may still hold valid;
  // masking it keeps it from being granted a second time.
  assign w_eligible = req_valid & ~r_done;
  assign w_winner   = (&w_eligible) ? ~r_last_grant : w_eligible[1];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state      <= IDLE;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_done       <= 2'b00;
      r_err        <= 1'b0;
      r_rdata      <= '0;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_psel       <= w_psel_next;
      r_penable    <= w_penable_next;
      r_pwrite     <= w_pwrite_next;
      r_paddr      <= w_paddr_next;
      r_pwdata     <= w_pwdata_next;
      r_done       <= w_done_next;
      r_err        <= w_err_next;
      r_rdata      <= w_rdata_next;
      r_cnt        <= w_cnt_next;
      r_last_grant <= w_last_grant_next;
      r_grant      <= w_grant_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_psel_next       = r_psel;
    w_penable_next    = r_penable;
    w_pwrite_next     = r_pwrite;
    w_paddr_next      = r_paddr;
    w_pwdata_next     = r_pwdata;
    w_done_next       = 2'b00;
    w_err_next        = 1'b0;
    w_rdata_next      = r_rdata;
    w_cnt_next        = r_cnt;
    w_last_grant_next = r_last_grant;
    w_grant_next      = r_grant;

    case (r_state)
      IDLE: begin
        w_psel_next    = 1'b0;
        w_penable_next = 1'b0;
        if (|w_eligible) begin
          w_grant_next      = w_winner;
          w_last_grant_next = w_winner;
          w_paddr_next      = w_winner ? req1_addr  : req0_addr;
          w_pwdata_next     = w_winner ? req1_wdata : req0_wdata;
          w_pwrite_next     = w_winner ? req1_write : req0_write;
          w_psel_next       = 1'b1;
          w_state_next      = SETUP;
        end
      end
      SETUP: begin
        w_penable_next = 1'b1;
        w_cnt_next     = '0;
        w_state_next   = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          w_state_next   = IDLE;
          w_psel_next    = 1'b0;
          w_penable_next = 1'b0;
          w_done_next    = r_grant ? 2'b10 : 2'b01;
          if (!r_pwrite) begin
            w_rdata_next = PRDATA;
          end
        end else if (r_cnt == CNT_LAST) begin
          // Last permitted wait cycle expired: abandon the transfer.
          w_state_next   = IDLE;
          w_psel_next    = 1'b0;
          w_penable_next = 1'b0;
          w_done_next    = r_grant ? 2'b10 : 2'b01;
          w_err_next     = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_next   = IDLE;
        w_psel_next    = 1'b0;
        w_penable_next = 1'b0;
      end
    endcase
  end

  assign PSELx     = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign req_done  = r_done;
  assign req_err   = r_err;
  assign req_rdata = r_rdata;

endmodule

// File: tb/tb_apb_arbiter_master.sv
// Directed bench for apb_arbiter_master: write, waited read, timeout,
// round-robin contention and asynchronous reset mid-transfer.
module tb_apb_arbiter_master;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [3:0]  req0_addr = '0, req1_addr = '0;
  logic [31:0] req0_wdata = '0, req1_wdata = '0;
  logic        req0_write = 1'b0, req1_write = 1'b0;
  logic [1:0]  req_done;
  logic        req_err;
  logic [31:0] req_rdata;
  logic        PSELx, PENABLE, PWRITE;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  apb_arbiter_master #(.ADDRESSWIDTH(4), .DATAWIDTH(32), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid),
    .req0_addr(req0_addr), .req1_addr(req1_addr),
    .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
    .req0_write(req0_write), .req1_write(req1_write),
    .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_psel"},  {31'd0, PSELx},   32'd0);
    check_eq({pfx, "_pen"},   {31'd0, PENABLE}, 32'd0);
    check_eq({pfx, "_pwr"},   {31'd0, PWRITE},  32'd0);
    check_eq({pfx, "_paddr"}, {28'd0, PADDR},   32'd0);
    check_eq({pfx, "_pwdat"}, PWDATA,           32'd0);
    check_eq({pfx, "_done"},  {30'd0, req_done}, 32'd0);
    check_eq({pfx, "_err"},   {31'd0, req_err}, 32'd0);
    check_eq({pfx, "_rdata"}, req_rdata,        32'd0);
  endtask

  logic [3:0] exp_addr [4];
  logic [1:0] exp_done [4];
  logic [1:0] done_seen;
  logic       psel_seen;

  initial begin
    exp_addr[0] = 4'd4; exp_addr[1] = 4'd9; exp_addr[2] = 4'd4; exp_addr[3] = 4'd9;
    exp_done[0] = 2'b01; exp_done[1] = 2'b10; exp_done[2] = 2'b01; exp_done[3] = 2'b10;

    // Reset state
    tick(); tick();
    check_all_zero("rst");
    PRESETn = 1'b1;
    tick();

    // Single write from req0, zero wait states
    req_valid = 2'b01; req0_addr = 4'd2; req0_wdata = 32'h5A; req0_write = 1'b1; PREADY = 1'b1;
    tick();
    check_eq("wr_setup_psel", {31'd0, PSELx},   32'd1);
    check_eq("wr_setup_pen",  {31'd0, PENABLE}, 32'd0);
    check_eq("wr_setup_addr", {28'd0, PADDR},   32'd2);
    check_eq("wr_setup_pwr",  {31'd0, PWRITE},  32'd1);
    check_eq("wr_setup_wdat", PWDATA,           32'h5A);
    req0_addr = 4'd7; req0_wdata = 32'hFFFF; req0_write = 1'b0;
    tick();
    check_eq("wr_acc_pen",    {31'd0, PENABLE}, 32'd1);
    check_eq("wr_acc_addr",   {28'd0, PADDR},   32'd2);
    check_eq("wr_acc_wdat",   PWDATA,           32'h5A);
    check_eq("wr_acc_pwr",    {31'd0, PWRITE},  32'd1);
    tick();
    check_eq("wr_done",       {30'd0, req_done}, 32'b01);
    check_eq("wr_err",        {31'd0, req_err},  32'd0);
    check_eq("wr_done_psel",  {31'd0, PSELx},    32'd0);
    tick();
    req_valid = 2'b00;
    check_eq("wr_done_pulse", {30'd0, req_done}, 32'd0);
    check_eq("wr_no_regrant", {31'd0, PSELx},    32'd0);
    tick();

    // Read from req1 with two wait states
    req_valid = 2'b10; req1_addr = 4'd3; req1_write = 1'b0; PREADY = 1'b0; PRDATA = 32'h0;
    tick();
    check_eq("rd_setup_addr", {28'd0, PADDR},   32'd3);
    check_eq("rd_setup_pwr",  {31'd0, PWRITE},  32'd0);
    tick();
    tick();
    check_eq("rd_wait_done",  {30'd0, req_done}, 32'd0);
    tick();
    PREADY = 1'b1; PRDATA = 32'h8;
    check_eq("rd_acc_pen",    {31'd0, PENABLE}, 32'd1);
    tick();
    check_eq("rd_done",       {30'd0, req_done}, 32'b10);
    check_eq("rd_rdata",      req_rdata,         32'h8);
    check_eq("rd_err",        {31'd0, req_err},  32'd0);
    req_valid = 2'b00; PRDATA = 32'h0;
    tick();
    tick();

    // Timeout: read with PREADY held low, rdata must keep the previous value
    req_valid = 2'b01; req0_addr = 4'd5; req0_write = 1'b0; PREADY = 1'b0; PRDATA = 32'hFF;
    tick();
    for (int c = 0; c < 16; c++) tick();
    check_eq("to_last_pen",   {31'd0, PENABLE},  32'd1);
    check_eq("to_last_done",  {30'd0, req_done}, 32'd0);
    tick();
    req_valid = 2'b00;
    check_eq("to_done",       {30'd0, req_done}, 32'b01);
    check_eq("to_err",        {31'd0, req_err},  32'd1);
    check_eq("to_psel",       {31'd0, PSELx},    32'd0);
    check_eq("to_rdata",      req_rdata,         32'h8);
    tick();
    check_eq("to_err_pulse",  {31'd0, req_err},  32'd0);
    check_eq("to_done_pulse", {30'd0, req_done}, 32'd0);
    PREADY = 1'b1;

    // Contention after a fresh reset: req0 first, then alternating
    PRESETn = 1'b0;
    tick();
    PRESETn = 1'b1;
    req0_addr = 4'd4; req1_addr = 4'd9; req0_write = 1'b1; req1_write = 1'b1;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("rr%0d_setup", k), {30'd0, PSELx, PENABLE}, 32'b10);
      check_eq($sformatf("rr%0d_addr", k),  {28'd0, PADDR},          {28'd0, exp_addr[k]});
      tick();
      tick();
      check_eq($sformatf("rr%0d_gap", k),   {31'd0, PSELx},          32'd0);
      check_eq($sformatf("rr%0d_done", k),  {30'd0, req_done},       {30'd0, exp_done[k]});
    end
    req_valid = 2'b00;
    tick();
    tick();

    // Asynchronous reset in the middle of ACCESS
    req_valid = 2'b10; req1_addr = 4'd6; req1_wdata = 32'h1234; req1_write = 1'b1; PREADY = 1'b0;
    tick();
    tick();
    check_eq("mr_in_access",  {31'd0, PENABLE}, 32'd1);
    #2;
    PRESETn = 1'b0;
    req_valid = 2'b00;
    #1;
    check_all_zero("mr_async");
    tick();
    PRESETn = 1'b1;
    PREADY = 1'b1;
    done_seen = 2'b00;
    psel_seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      done_seen = done_seen | req_done;
      psel_seen = psel_seen | PSELx;
    end
    check_eq("mr_no_done",    {30'd0, done_seen}, 32'd0);
    check_eq("mr_no_psel",    {31'd0, psel_seen}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
